// File: rtl/led_sequencer.sv
// LED pattern sequencer: divider-paced rotate-left/right, bounce and hold over an N-bit LED bank.
// Optional LED_PWM_EN adds a registered PWM brightness gate on the LED outputs.
module led_sequencer #(
  parameter int unsigned NUM_LEDS = 5,
  parameter int unsigned STEP_DIV = 12000000,
  parameter logic [NUM_LEDS-1:0] SEED = NUM_LEDS'(5'b00011),
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [1:0]          MODE,
  input  logic                PAUSE,
  input  logic                LOAD,
  input  logic [NUM_LEDS-1:0] LOAD_PATTERN,
  input  logic [PWM_BITS-1:0] BRIGHTNESS,
  output logic [NUM_LEDS-1:0] LED,
  output logic                STEP
);

  localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  localparam logic [0:0] DIR_DOWN = 1'b0;
  localparam logic [0:0] DIR_UP   = 1'b1;

  localparam logic [1:0] MODE_ROTL   = 2'b00;
  localparam logic [1:0] MODE_ROTR   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [NUM_LEDS-1:0] pattern_q, pattern_d;
  logic [0:0]          dir_q, dir_d;
  logic                step_q, step_d;

  logic                step_c;
  logic [NUM_LEDS-1:0] rotl_c;
  logic [NUM_LEDS-1:0] rotr_c;

  assign step_c = !PAUSE && (div_cnt_q == DIV_LAST);
  assign rotl_c = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
  assign rotr_c = {pattern_q[0], pattern_q[NUM_LEDS-1:1]};

  // Next-state: LOAD wins over a coincident step, which is then dropped.
  always_comb begin
    div_cnt_d = div_cnt_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    if (LOAD) begin
      pattern_d = LOAD_PATTERN;
      div_cnt_d = '0;
      dir_d     = DIR_UP;
    end else if (!PAUSE) begin
      if (step_c) begin
        div_cnt_d = '0;
        step_d    = 1'b1;
        case (MODE)
          MODE_ROTL: pattern_d = rotl_c;
          MODE_ROTR: pattern_d = rotr_c;
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pattern_q[NUM_LEDS-1]) begin
                dir_d     = DIR_DOWN;
                pattern_d = rotr_c;
              end else begin
                pattern_d = rotl_c;
              end
            end else begin
              if (pattern_q[0]) begin
                dir_d     = DIR_UP;
                pattern_d = rotl_c;
              end else begin
                pattern_d = rotr_c;
              end
            end
          end
          default: pattern_d = pattern_q;
        endcase
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      div_cnt_q <= '0;
      pattern_q <= SEED;
      dir_q     <= DIR_UP;
      step_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
    end
  end

  assign STEP = step_q;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [NUM_LEDS-1:0] led_q;
  logic                pwm_on_c;

  assign pwm_on_c = (pwm_cnt_q < BRIGHTNESS);

  // Free-running PWM counter gates the pattern; LED lags pattern by one cycle.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      led_q     <= pattern_q & {NUM_LEDS{pwm_on_c}};
    end
  end

  assign LED = led_q;
`else
  logic unused_brightness;
  assign unused_brightness = ^BRIGHTNESS;
  assign LED = pattern_q;
`endif

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer driving an N-bit LED bank from a free-running step divider. It supports rotate-left, rotate-right, bounce and hold modes, runtime pattern load and pause, and a one-cycle step strobe. It sits at board top level between the system clock and the LED pins, and generalises the fixed 4-LED power-on rotator.

## Interface
- NUM_LEDS, 5, LED bank width; at least 2.
- STEP_DIV, 12000000, CLK cycles per pattern step; at least 2.
- SEED, {NUM_LEDS{1'b0}} | 'b00011, pattern loaded at reset.
- PWM_BITS, 4, brightness resolution; used only with LED_PWM_EN.
- CLK  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- MODE  in  2  00 rotate left (toward MSB), 01 rotate right, 10 bounce, 11 hold.
- PAUSE  in  1  freezes the divider; no steps while high.
- LOAD  in  1  one-cycle strobe that loads LOAD_PATTERN.
- LOAD_PATTERN  in  NUM_LEDS  pattern for LOAD.
- BRIGHTNESS  in  PWM_BITS  duty control; ignored without LED_PWM_EN.
- LED  out  NUM_LEDS  LED drive, active high.
- STEP  out  1  one-cycle pulse on every pattern step.

## Operation
- Internal state:
  - `div_cnt` counter, $clog2(STEP_DIV) bits.
  - `pattern` register, NUM_LEDS bits.
  - `dir` register, 1 = up (toward MSB).
- Reset (RESET_N low at an edge) sets: div_cnt = 0, pattern = SEED, dir = up, STEP = 0.
- Divider: when PAUSE is low, div_cnt increments. When div_cnt == STEP_DIV-1 it wraps to 0 and a step occurs. When PAUSE is high, div_cnt holds and no step occurs.
- On a step, `pattern` updates from MODE as sampled on that edge:
  - 00: pattern <= {pattern[N-2:0], pattern[N-1]}.
  - 01: pattern <= {pattern[0], pattern[N-1:1]}.
  - 10 with dir up and pattern[N-1] = 1: dir <= down and rotate right.
  - 10 with dir up and pattern[N-1] = 0: rotate left.
  - 10 with dir down and pattern[0] = 1: dir <= up and rotate left.
  - 10 with dir down and pattern[0] = 0: rotate right.
  - 11: pattern unchanged; STEP still pulses.
- `dir` changes only in mode 10. Switching into mode 10 uses the retained `dir`.
- LOAD high: pattern <= LOAD_PATTERN, div_cnt <= 0, dir <= up, STEP = 0 that cycle.
  - LOAD overrides a coincident step; that step is lost.
  - LOAD also acts while PAUSE is high.
- Priority: RESET_N > LOAD > step.
- All-zero pattern: steps continue and LED stays 0. All-ones pattern in bounce: dir toggles every step while LED stays all-ones.

## Timing
- STEP is registered and goes high on the same edge as the `pattern` update.
- First step comes STEP_DIV cycles after the first edge with RESET_N high, provided PAUSE stays low.
- Step period is exactly STEP_DIV cycles while PAUSE is low. Pausing stretches the period by the number of paused cycles, and div_cnt resumes from its held value.
- Without LED_PWM_EN, LED = pattern with no extra delay. LED reset value is SEED.
- A MODE change takes effect at the next step. LOAD_PATTERN appears on LED at the edge following the LOAD cycle, plus 1 cycle with PWM.
- Reset mid-count: the next edge with RESET_N low restores all reset values, with no partial step.

## Configuration
- `LED_PWM_EN` defined:
  - Adds a free-running PWM_BITS-bit `pwm_cnt` (reset 0) that wraps.
  - `on` = (pwm_cnt < BRIGHTNESS).
  - LED is registered: LED <= pattern & {N{on}}. Reset value of LED is 0, and LED lags `pattern` by 1 cycle.
  - BRIGHTNESS = 0 gives LED permanently 0. Maximum BRIGHTNESS gives a duty of (2^PWM_BITS - 1)/2^PWM_BITS.
- `LED_PWM_EN` undefined:
  - No PWM logic; BRIGHTNESS is unused.
  - LED = pattern, reset value SEED.

## Test plan
- Reset, NUM_LEDS=5, SEED=5'b00011, STEP_DIV=4, MODE=00 -> LED=00011 during reset; STEP on the 4th edge after release; LED 00110, 01100, 11000, 10001 at 4-cycle intervals.
- MODE=10, SEED=5'b00001, STEP_DIV=2 -> LED 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010.
- PAUSE high for 3 cycles in mid-count -> next STEP arrives 3 cycles later than unpaused; pattern and div_cnt are held.
- LOAD with LOAD_PATTERN=10101 on the same cycle div_cnt==STEP_DIV-1 -> LED=10101, no STEP that cycle, next STEP STEP_DIV cycles later.
- MODE=11 -> STEP pulses every STEP_DIV cycles and LED is constant. RESET_N low mid-count -> LED=SEED, with the next STEP STEP_DIV cycles after release.
- LED_PWM_EN, PWM_BITS=4, BRIGHTNESS=4, pattern 00011 -> LED[1:0]=11 for 4 of every 16 cycles, LED[4:2]=0. BRIGHTNESS=0 -> LED=0 throughout.
